dec_blk_bits_tracker: RTL and testbench
=======================================

# dec_blk_bits_tracker

Decoder-side per-block bit accounting stage, directly upstream of the decoder rate control. It counts the bits the syntax parser consumes from each of the four substreams (SSM0–SSM3) during one block. At every block boundary it publishes the per-substream totals together with the block-start strobe and the first-line-of-slice flag that rate control needs. It also tracks block position within the slice and signals slice completion.

## Interface
Parameters:
- NUM_SSM, 4, number of substreams; the design is fixed at 4, and the parameter exists only for package consistency.
- LEN_W, 6, width of one consume length (max 63 bits per step).

Ports:
- clk, input, 1, clock.
- rstn, input, 1, reset: asynchronous, active-low.
- slice_start, input, 1, one-cycle pulse that starts a slice.
- r_sliceWidth, input, 16, slice width in pixels; blocks per line = r_sliceWidth[10:3].
- r_sliceHeight, input, 16, slice height in pixels; block rows = r_sliceHeight[15:1].
- ssm_cons_vld, input, 4, per-substream consume strobe.
- ssm_cons_len, input, 4*LEN_W, per-substream consumed bit count; SSMn occupies bits [n*LEN_W +: LEN_W].
- blk_parse_done, input, 1, pulse marking the last parse step of the current block.
- nxtBlkbitsSsm0..3, output, 8 each, bit totals of the last completed block.
- blk_bits_total, output, 10, sum of the four totals.
- start_dec, output, 1, one-cycle strobe: new block totals are valid.
- isFls, output, 1, the completed block lies in block row 0.
- blk_x, output, 8; blk_y, output, 15, position of the next block to parse.
- slice_done, output, 1, one-cycle pulse after the final block of the slice.
- bits_ovf, output, 1, sticky; a substream accumulator saturated.

## Operation
- States:
  - IDLE, the reset state.
  - ACTIVE.
  - DONE, which lasts exactly one cycle.
- State transitions:
  - IDLE → ACTIVE on slice_start.
  - ACTIVE → DONE on a blk_parse_done whose block is the last one (blk_x == blocks per line − 1 and blk_y == block rows − 1).
  - DONE → IDLE unconditionally.
  - slice_start in any state forces ACTIVE: accumulators, blk_x, blk_y and bits_ovf are cleared, and published outputs are held.
- Accumulation:
  - In ACTIVE, each ssm_cons_vld[n] adds ssm_cons_len[n] to acc[n], which is 8 bits wide.
  - An add that exceeds 255 saturates acc[n] at 255 and sets bits_ovf.
  - In IDLE and DONE, consume strobes are ignored.
- Block boundary:
  - On blk_parse_done in ACTIVE, the same-cycle consume strobes count toward the finishing block.
  - The registered outputs load acc + same-cycle len, saturated as above.
  - The accumulators then clear to 0.
  - blk_parse_done in IDLE or DONE is ignored: no strobe and no update.
- Position:
  - blk_x increments on each block boundary and wraps to 0 at blocks per line − 1, at which point blk_y increments.
  - isFls is loaded with (blk_y == 0) of the completed block.
- blk_bits_total is the zero-extended 10-bit sum of the four registered totals.
- Reset values:
  - All outputs are 0, including isFls and bits_ovf.
  - State is IDLE and accumulators are 0.

## Timing
- blk_parse_done at cycle T produces:
  - at T+1: nxtBlkbitsSsm*, blk_bits_total and isFls updated; start_dec high for exactly one cycle; blk_x/blk_y advanced.
- The final block additionally produces slice_done at T+1, coincident with start_dec, while the state is DONE.
- blk_parse_done is legal on back-to-back cycles, giving one start_dec per cycle.
- An accumulator cleared at T+1 accepts new consumes at T+1.
- slice_start at T clears everything at T+1; a blk_parse_done in the same cycle T is dropped.
- Asynchronous reset mid-block discards the partial counts; outputs go to 0 immediately.

## Configuration
- DEC_BITS_STAT_EN:
  - Defined: adds output slice_bits [23:0], the running sum of all published blk_bits_total in the slice. It is cleared on slice_start and saturates at 2^24−1.
  - Undefined: the port and its counter are absent, and all other behaviour is identical.

## Structure
- Shared decoder package:
  - NUM_SSM, LEN_W and the block geometry constants (8x2 block, 16 pixels).
  - The state enum {IDLE, ACTIVE, DONE}.
  - A saturating-add function used by both the accumulators and the statistics counter.
- One sub-module, dec_ssm_bit_acc, instantiated four times: a single substream's 8-bit saturating accumulator with clear-on-boundary, plus its published register and overflow flag.

## Test plan
- Slice 32x4 pixels (4 blocks/line, 2 block rows): 8 blocks, each with SSM0..3 consuming 10,20,30,40 → 8 start_dec pulses, each with totals 10/20/30/40 and blk_bits_total=100; isFls=1 for blocks 0–3 and 0 for blocks 4–7; slice_done coincides with the 8th pulse.
- SSM2 consumes 63 five times in one block → nxtBlkbitsSsm2=255 and bits_ovf=1; bits_ovf persists until the next slice_start.
- Consume of len 5 on SSM1 in the same cycle as blk_parse_done, after an accumulated 12 → nxtBlkbitsSsm1=17; next block starts at 0.
- blk_parse_done on 3 consecutive cycles with no consumes → 3 start_dec pulses with all-zero totals; blk_x goes 1,2,3.
- slice_start issued mid-block after 7 bits on SSM0, then one block of 4 bits on SSM0 → nxtBlkbitsSsm0=4 and blk_x,blk_y=0,0 before the boundary.
- With DEC_BITS_STAT_EN defined and the first scenario → slice_bits=800 after slice_done.

Source files
------------

// File: rtl/dec_blk_bits_tracker_pkg.sv
// rtl/dec_blk_bits_tracker_pkg.sv - shared constants, state enum and saturating add for the block bit tracker
package dec_blk_bits_tracker_pkg;

  localparam int NUM_SSM = 4;
  localparam int LEN_W   = 6;
  localparam int ACC_W   = 8;
  localparam int ACC_MAX = 255;
  localparam int BLK_W   = 8;
  localparam int BLK_H   = 2;
  localparam int BLK_PIX = BLK_W * BLK_H;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Returns {saturated, result}; result is clamped to max_v when a + b exceeds it.
  function automatic logic [24:0] sat_add(input logic [23:0] a,
                                          input logic [23:0] b,
                                          input logic [23:0] max_v);
    logic [24:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) sat_add = {1'b1, max_v};
    else                   sat_add = {1'b0, s[23:0]};
  endfunction

endpackage

// File: rtl/dec_ssm_bit_acc.sv
// rtl/dec_ssm_bit_acc.sv - one substream's saturating bit accumulator with published total and overflow flag
module dec_ssm_bit_acc
  import dec_blk_bits_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             bnd_i,
  output logic [ACC_W-1:0] tot_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] tot_q, tot_d;
  logic             ovf_q, ovf_d;
  logic [24:0]      add_r;
  logic [ACC_W-1:0] sum;
  logic             sat;

  // Saturating sum of the running count and this cycle's consume (if any).
  always_comb begin
    add_r = sat_add(24'(acc_q), vld_i ? 24'(len_i) : 24'd0, 24'(ACC_MAX));
    sum   = add_r[ACC_W-1:0];
    sat   = add_r[24] | (|add_r[23:ACC_W]);
  end

  // Next state: slice start clears, a boundary publishes the finishing block and restarts the count.
  always_comb begin
    acc_d = acc_q;
    tot_d = tot_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (vld_i && sat) ovf_d = 1'b1;
      if (bnd_i) begin
        tot_d = sum;
        acc_d = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      tot_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      tot_q <= tot_d;
      ovf_q <= ovf_d;
    end
  end

  assign tot_o = tot_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/dec_blk_bits_tracker.sv
// rtl/dec_blk_bits_tracker.sv - per-block substream bit accounting for rate control (option: DEC_BITS_STAT_EN adds slice_bits)
module dec_blk_bits_tracker
  import dec_blk_bits_tracker_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     slice_start,
  input  logic [15:0]              r_sliceWidth,
  input  logic [15:0]              r_sliceHeight,
  input  logic [NUM_SSM-1:0]       ssm_cons_vld,
  input  logic [NUM_SSM*LEN_W-1:0] ssm_cons_len,
  input  logic                     blk_parse_done,
  output logic [7:0]               nxtBlkbitsSsm0,
  output logic [7:0]               nxtBlkbitsSsm1,
  output logic [7:0]               nxtBlkbitsSsm2,
  output logic [7:0]               nxtBlkbitsSsm3,
  output logic [9:0]               blk_bits_total,
  output logic                     start_dec,
  output logic                     isFls,
  output logic [7:0]               blk_x,
  output logic [14:0]              blk_y,
  output logic                     slice_done,
  output logic                     bits_ovf
`ifdef DEC_BITS_STAT_EN
  ,
  output logic [23:0]              slice_bits
`endif
);

  state_e            state_q, state_d;
  logic [7:0]        blk_x_q, blk_x_d;
  logic [14:0]       blk_y_q, blk_y_d;
  logic              isFls_q, isFls_d;
  logic              start_dec_q, slice_done_q;
  logic [7:0]        bpl_m1;
  logic [14:0]       rows_m1;
  logic              active, blk_done, last_blk;
  logic [ACC_W-1:0]  tot [NUM_SSM];
  logic [NUM_SSM-1:0] ovf_vec;
  logic              unused_geom;

  assign bpl_m1      = r_sliceWidth[10:3] - 8'd1;
  assign rows_m1     = r_sliceHeight[15:1] - 15'd1;
  assign unused_geom = ^{r_sliceWidth[15:11], r_sliceWidth[2:0], r_sliceHeight[0]};

  assign active   = (state_q == ST_ACTIVE);
  assign blk_done = active & blk_parse_done & ~slice_start;
  assign last_blk = (blk_x_q == bpl_m1) && (blk_y_q == rows_m1);

  // Slice FSM next state; slice_start overrides every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_ACTIVE: if (blk_done && last_blk) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (slice_start) state_d = ST_ACTIVE;
  end

  // Block position within the slice and first-line flag of the completed block.
  always_comb begin
    blk_x_d = blk_x_q;
    blk_y_d = blk_y_q;
    isFls_d = isFls_q;
    if (slice_start) begin
      blk_x_d = '0;
      blk_y_d = '0;
    end else if (blk_done) begin
      isFls_d = (blk_y_q == 15'd0);
      if (blk_x_q == bpl_m1) begin
        blk_x_d = '0;
        blk_y_d = blk_y_q + 15'd1;
      end else begin
        blk_x_d = blk_x_q + 8'd1;
      end
    end
  end

  // State, position and strobe registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      blk_x_q      <= '0;
      blk_y_q      <= '0;
      isFls_q      <= 1'b0;
      start_dec_q  <= 1'b0;
      slice_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_x_q      <= blk_x_d;
      blk_y_q      <= blk_y_d;
      isFls_q      <= isFls_d;
      start_dec_q  <= blk_done;
      slice_done_q <= blk_done & last_blk;
    end
  end

  for (genvar g = 0; g < NUM_SSM; g++) begin : g_acc
    dec_ssm_bit_acc u_acc (
      .clk   (clk),
      .rstn  (rstn),
      .clr_i (slice_start),
      .en_i  (active),
      .vld_i (ssm_cons_vld[g]),
      .len_i (ssm_cons_len[g*LEN_W +: LEN_W]),
      .bnd_i (blk_done),
      .tot_o (tot[g]),
      .ovf_o (ovf_vec[g])
    );
  end

  assign nxtBlkbitsSsm0 = tot[0];
  assign nxtBlkbitsSsm1 = tot[1];
  assign nxtBlkbitsSsm2 = tot[2];
  assign nxtBlkbitsSsm3 = tot[3];
  assign blk_bits_total = {2'b00, tot[0]} + {2'b00, tot[1]} + {2'b00, tot[2]} + {2'b00, tot[3]};
  assign start_dec      = start_dec_q;
  assign slice_done     = slice_done_q;
  assign isFls          = isFls_q;
  assign blk_x          = blk_x_q;
  assign blk_y          = blk_y_q;
  assign bits_ovf       = |ovf_vec;

`ifdef DEC_BITS_STAT_EN
  logic [23:0] slice_bits_q, slice_bits_d;
  logic [24:0] stat_add;

  // Running slice total: adds each block total the cycle it is published.
  always_comb begin
    stat_add     = sat_add(slice_bits_q, 24'(blk_bits_total), 24'hFFFFFF);
    slice_bits_d = slice_bits_q;
    if (slice_start)      slice_bits_d = '0;
    else if (start_dec_q) slice_bits_d = stat_add[24] ? 24'hFFFFFF : stat_add[23:0];
  end

  // Slice statistics register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) slice_bits_q <= '0;
    else       slice_bits_q <= slice_bits_d;
  end

  assign slice_bits = slice_bits_q;
`endif

endmodule

// File: tb/tb_dec_blk_bits_tracker.sv
// tb/tb_dec_blk_bits_tracker.sv - scoreboard bench for dec_blk_bits_tracker (DEC_BITS_STAT_EN optional)
module tb_dec_blk_bits_tracker;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        slice_start = 1'b0;
  logic [15:0] r_sliceWidth = '0;
  logic [15:0] r_sliceHeight = '0;
  logic [3:0]  ssm_cons_vld = '0;
  logic [23:0] ssm_cons_len = '0;
  logic        blk_parse_done = 1'b0;
  logic [7:0]  nxtBlkbitsSsm0, nxtBlkbitsSsm1, nxtBlkbitsSsm2, nxtBlkbitsSsm3;
  logic [9:0]  blk_bits_total;
  logic        start_dec, isFls, slice_done, bits_ovf;
  logic [7:0]  blk_x;
  logic [14:0] blk_y;
`ifdef DEC_BITS_STAT_EN
  logic [23:0] slice_bits;
`endif

  dec_blk_bits_tracker dut (
    .clk            (clk),
    .rstn           (rstn),
    .slice_start    (slice_start),
    .r_sliceWidth   (r_sliceWidth),
    .r_sliceHeight  (r_sliceHeight),
    .ssm_cons_vld   (ssm_cons_vld),
    .ssm_cons_len   (ssm_cons_len),
    .blk_parse_done (blk_parse_done),
    .nxtBlkbitsSsm0 (nxtBlkbitsSsm0),
    .nxtBlkbitsSsm1 (nxtBlkbitsSsm1),
    .nxtBlkbitsSsm2 (nxtBlkbitsSsm2),
    .nxtBlkbitsSsm3 (nxtBlkbitsSsm3),
    .blk_bits_total (blk_bits_total),
    .start_dec      (start_dec),
    .isFls          (isFls),
    .blk_x          (blk_x),
    .blk_y          (blk_y),
    .slice_done     (slice_done),
    .bits_ovf       (bits_ovf)
`ifdef DEC_BITS_STAT_EN
    ,
    .slice_bits     (slice_bits)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int t0, t1, t2, t3, tot, x, y;
    bit fls, sd, ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: true (unbounded) per-substream sums and block index in the slice.
  int m_sum [4];
  int m_k, m_bpl, m_rows, m_slice_bits;
  bit m_active, m_ovf;

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at a negedge, advance the model, then wait for the next negedge.
  task automatic step(input bit ss, input logic [3:0] vld,
                      input int l0, input int l1, input int l2, input int l3, input bit pd);
    int   l [4];
    exp_t e;
    l = '{l0, l1, l2, l3};
    slice_start    = ss;
    ssm_cons_vld   = vld;
    ssm_cons_len   = {6'(l3), 6'(l2), 6'(l1), 6'(l0)};
    blk_parse_done = pd;
    if (ss) begin
      m_sum = '{0, 0, 0, 0};
      m_k = 0; m_ovf = 0; m_active = 1; m_slice_bits = 0;
      m_bpl  = int'(r_sliceWidth[10:3]);
      m_rows = int'(r_sliceHeight[15:1]);
    end else if (m_active) begin
      for (int n = 0; n < 4; n++) begin
        if (vld[n]) begin
          m_sum[n] += l[n];
          if (m_sum[n] > 255) m_ovf = 1;
        end
      end
      if (pd) begin
        e.t0 = sat255(m_sum[0]); e.t1 = sat255(m_sum[1]);
        e.t2 = sat255(m_sum[2]); e.t3 = sat255(m_sum[3]);
        e.tot = e.t0 + e.t1 + e.t2 + e.t3;
        e.fls = ((m_k / m_bpl) == 0);
        e.sd  = (m_k == m_bpl * m_rows - 1);
        e.x   = (m_k + 1) % m_bpl;
        e.y   = (m_k + 1) / m_bpl;
        e.ovf = m_ovf;
        q.push_back(e);
        m_slice_bits += e.tot;
        m_k++;
        m_sum = '{0, 0, 0, 0};
        if (e.sd) m_active = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_geom(input int bpl, input int rows);
    r_sliceWidth  = 16'(bpl * 8);
    r_sliceHeight = 16'(rows * 2);
  endtask

  // Monitor: every published block is compared against the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn) begin
      if (start_dec) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_start_dec actual=1 expected=0");
        end else begin
          e = q.pop_front();
          chk("ssm0", int'(nxtBlkbitsSsm0), e.t0);
          chk("ssm1", int'(nxtBlkbitsSsm1), e.t1);
          chk("ssm2", int'(nxtBlkbitsSsm2), e.t2);
          chk("ssm3", int'(nxtBlkbitsSsm3), e.t3);
          chk("blk_bits_total", int'(blk_bits_total), e.tot);
          chk("isFls", int'(isFls), int'(e.fls));
          chk("slice_done", int'(slice_done), int'(e.sd));
          chk("blk_x", int'(blk_x), e.x);
          chk("blk_y", int'(blk_y), e.y);
          chk("bits_ovf", int'(bits_ovf), int'(e.ovf));
        end
      end else begin
        chk("slice_done_without_start_dec", int'(slice_done), 0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ssm0"}, int'(nxtBlkbitsSsm0), 0);
    chk({tag, "_total"}, int'(blk_bits_total), 0);
    chk({tag, "_start_dec"}, int'(start_dec), 0);
    chk({tag, "_isFls"}, int'(isFls), 0);
    chk({tag, "_blk_xy"}, int'(blk_x) + int'(blk_y), 0);
    chk({tag, "_ovf"}, int'(bits_ovf), 0);
  endtask

  initial begin
    m_sum = '{0, 0, 0, 0};
    m_k = 0; m_bpl = 1; m_rows = 1; m_active = 0; m_ovf = 0; m_slice_bits = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // 32x4 slice, 8 blocks of 10/20/30/40.
    set_geom(4, 2);
    step(1, 4'h0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 8; b++) begin
      step(0, 4'hF, 10, 20, 30, 40, 0);
      step(0, 4'h0, 0, 0, 0, 0, 1);
    end
    idle(3);
    chk("first_slice_total_bits", m_slice_bits, 800);
`ifdef DEC_BITS_STAT_EN
    chk("slice_bits", int'(slice_bits), 800);
`endif

    // Back-to-back boundaries, same-cycle consume, then saturation in the same slice.
    step(1, 4'h0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 3; b++) step(0, 4'h0, 0, 0, 0, 0, 1);
    step(0, 4'b0010, 0, 12, 0, 0, 0);
    step(0, 4'b0010, 0, 5, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 4'b0100, 0, 0, 63, 0, 0);
    step(0, 4'h0, 0, 0, 0, 0, 1);
    idle(2);
    chk("bits_ovf_sticky", int'(bits_ovf), 1);
    step(0, 4'b0001, 3, 0, 0, 0, 1);

    // Slice restart in the middle of a block discards the partial count.
    step(0, 4'b0001, 7, 0, 0, 0, 0);
    step(1, 4'h0, 0, 0, 0, 0, 0);
    chk("restart_blk_x", int'(blk_x), 0);
    chk("restart_blk_y", int'(blk_y), 0);
    chk("restart_ovf_clear", int'(bits_ovf), 0);
    step(0, 4'b0001, 4, 0, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0, 0, 1);

    // Asynchronous reset with a partial block in flight.
    step(0, 4'b1111, 9, 9, 9, 9, 0);
    #2 rstn = 1'b0;
    #1 chk_all_zero("async_reset");
    m_active = 0; m_sum = '{0, 0, 0, 0}; m_ovf = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Randomised slices of varying geometry with occasional restarts.
    for (int c = 0; c < 1500; c++) begin
      bit ss;
      ss = (!m_active && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 199) == 0);
      if (ss) set_geom($urandom_range(1, 5), $urandom_range(1, 3));
      step(ss, 4'($urandom), $urandom_range(0, 63), $urandom_range(0, 63),
           $urandom_range(0, 63), $urandom_range(0, 63), ($urandom_range(0, 2) == 0));
    end
    idle(3);
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
